// File: rtl/ringvco_freq_counter.sv
// Ring-VCO frequency counter: synchronizes osc_in into clk, counts its rising
// edges over a programmable gate window and reports the result via start/done.
module ringvco_freq_counter #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             osc_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ACC_ZERO = {CNT_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};

  state_t           state_r, state_nxt_s;
  logic             s1_r, s2_r, s3_r;
  logic             rise_s;
  logic [WIN_W-1:0] win_r, win_nxt_s;
  logic [CNT_W-1:0] acc_r, acc_nxt_s;
  logic             ovf_r, ovf_nxt_s;

  // Two-flop synchronizer plus edge-detect flop for osc_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= osc_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise_s = s2_r & ~s3_r;

  // Next-state, window countdown and saturating edge accumulation
  always_comb begin
    state_nxt_s = state_r;
    win_nxt_s   = win_r;
    acc_nxt_s   = acc_r;
    ovf_nxt_s   = ovf_r;
    case (state_r)
      GATE: begin
        win_nxt_s = win_r - WIN_W'(1);
        if (rise_s) begin
          if (acc_r == ACC_MAX) begin
            ovf_nxt_s = 1'b1;
          end else begin
            acc_nxt_s = acc_r + CNT_W'(1);
          end
        end else begin
          acc_nxt_s = acc_r;
        end
        if (win_r == WIN_W'(1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = GATE;
        end
      end
      IDLE, DONE: begin
        if (start) begin
          acc_nxt_s = ACC_ZERO;
          ovf_nxt_s = 1'b0;
          if (win_len != WIN_ZERO) begin
            state_nxt_s = GATE;
            win_nxt_s   = win_len;
          end else begin
            state_nxt_s = DONE;
            win_nxt_s   = WIN_ZERO;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; result captured on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      win_r    <= WIN_ZERO;
      acc_r    <= ACC_ZERO;
      ovf_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= ACC_ZERO;
      overflow <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      win_r   <= win_nxt_s;
      acc_r   <= acc_nxt_s;
      ovf_r   <= ovf_nxt_s;
      busy    <= (state_nxt_s == GATE);
      done    <= (state_nxt_s == DONE);
      if (state_nxt_s == DONE) begin
        count    <= acc_nxt_s;
        overflow <= ovf_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_ringvco_freq_counter.sv
// Scoreboard bench: a 4-bit and a 16-bit counter share one stimulus stream;
// expected results are queued at start and popped by monitors on done.
module tb_ringvco_freq_counter;

  logic        clk = 1'b0;
  logic        rst_n, start, osc_in;
  logic [15:0] win_len;
  logic        busy4, done4, ovf4, busy16, done16, ovf16;
  logic [3:0]  count4;
  logic [15:0] count16;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] c;
    logic        o;
  } exp_t;

  exp_t q4[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  ringvco_freq_counter #(.CNT_W(4), .WIN_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .osc_in(osc_in),
    .busy(busy4), .done(done4), .count(count4), .overflow(ovf4)
  );

  ringvco_freq_counter #(.CNT_W(16), .WIN_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .osc_in(osc_in),
    .busy(busy16), .done(done16), .count(count16), .overflow(ovf16)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_push(input int c4, input int o4, input int c16, input int o16);
    exp_t e;
    e.c = 16'(c4);  e.o = 1'(o4);  q4.push_back(e);
    e.c = 16'(c16); e.o = 1'(o16); q16.push_back(e);
  endtask

  // Result monitors: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL mon4_unexpected_done: got count=%0d ovf=%0d expected no done", count4, ovf4);
      end else begin
        e = q4.pop_front();
        if (count4 !== e.c[3:0] || ovf4 !== e.o) begin
          errors++;
          $display("FAIL mon4_result: got count=%0d ovf=%0d expected count=%0d ovf=%0d",
                   count4, ovf4, e.c[3:0], e.o);
        end
      end
    end
    if (done16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL mon16_unexpected_done: got count=%0d ovf=%0d expected no done", count16, ovf16);
      end else begin
        e = q16.pop_front();
        if (count16 !== e.c || ovf16 !== e.o) begin
          errors++;
          $display("FAIL mon16_result: got count=%0d ovf=%0d expected count=%0d ovf=%0d",
                   count16, ovf16, e.c, e.o);
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] w);
    start   = 1'b1;
    win_len = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulses(input int n, input int hi, input int lo, input int d);
    repeat (d) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      osc_in = 1'b1;
      repeat (hi) @(negedge clk);
      osc_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  // Watches a run from the first gate cycle; stops on the negedge of the done cycle
  task automatic watch(input int limit, input logic [3:0] p4, input logic [15:0] p16,
                       output int busy_n, output int lat, output int hold_bad);
    busy_n = 0; lat = -1; hold_bad = 0;
    for (int i = 1; i <= limit; i++) begin
      if (done4) begin
        lat = i;
        break;
      end
      if (busy4) busy_n++;
      if (count4 !== p4 || count16 !== p16) hold_bad++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int bn, lat, hb, acc;
    rst_n = 1'b0; start = 1'b0; win_len = 16'd0; osc_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy4 | busy16, 0);
    chk("reset_done", done4 | done16, 0);
    chk("reset_count", count4 + count16, 0);
    chk("reset_ovf", ovf4 | ovf16, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic count
    sb_push(10, 0, 10, 0);
    do_start(16'd100);
    fork
      pulses(10, 3, 3, 5);
      watch(300, 4'd0, 16'd0, bn, lat, hb);
    join
    chk("basic_busy_cycles", bn, 100);
    chk("basic_done_latency", lat, 101);
    chk("basic_busy_in_done", busy4, 0);
    chk("basic_hold", hb, 0);
    @(negedge clk);

    // Zero window while osc toggles
    fork
      pulses(6, 1, 1, 0);
      begin
        @(negedge clk);
        sb_push(0, 0, 0, 0);
        do_start(16'd0);
        chk("zero_done_next", done4, 1);
        acc = 0;
        repeat (5) begin
          acc += int'(busy4) + int'(busy16);
          @(negedge clk);
        end
        chk("zero_busy_never", acc, 0);
      end
    join
    repeat (4) @(negedge clk);

    // Saturation
    sb_push(15, 1, 20, 0);
    do_start(16'd200);
    fork
      pulses(20, 3, 3, 5);
      watch(400, 4'd0, 16'd0, bn, lat, hb);
    join
    chk("sat_busy_cycles", bn, 200);
    chk("sat_done_latency", lat, 201);
    @(negedge clk);

    sb_push(3, 0, 3, 0);
    do_start(16'd50);
    fork
      pulses(3, 3, 3, 5);
      watch(200, 4'd15, 16'd20, bn, lat, hb);
    join
    chk("sat_follow_latency", lat, 51);
    chk("sat_follow_hold", hb, 0);
    @(negedge clk);

    // Ignored start during gate, result hold
    sb_push(7, 0, 7, 0);
    do_start(16'd100);
    fork
      pulses(7, 3, 3, 5);
      begin
        repeat (9) @(negedge clk);
        start = 1'b1; win_len = 16'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        start = 1'b1; win_len = 16'd0;
        @(negedge clk);
        start = 1'b0;
      end
      watch(300, 4'd3, 16'd3, bn, lat, hb);
    join
    chk("ign_done_latency", lat, 101);
    chk("ign_busy_cycles", bn, 100);
    chk("ign_hold", hb, 0);
    @(negedge clk);

    // Back-to-back
    sb_push(2, 0, 2, 0);
    do_start(16'd20);
    fork
      pulses(2, 3, 3, 3);
      watch(100, 4'd7, 16'd7, bn, lat, hb);
    join
    chk("b2b_first_latency", lat, 21);
    sb_push(4, 0, 4, 0);
    do_start(16'd20);
    chk("b2b_busy_next", busy4, 1);
    fork
      pulses(4, 2, 2, 0);
      watch(100, 4'd2, 16'd2, bn, lat, hb);
    join
    chk("b2b_second_latency", lat, 21);
    chk("b2b_second_busy", bn, 20);
    @(negedge clk);

    // Reset mid-gate
    do_start(16'd100);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy4 | busy16, 0);
    chk("rst_done", done4 | done16, 0);
    chk("rst_count", count4 + count16, 0);
    chk("rst_ovf", ovf4 | ovf16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    acc = 0;
    repeat (120) begin
      acc += int'(done4) + int'(done16);
      @(negedge clk);
    end
    chk("rst_no_done", acc, 0);

    sb_push(2, 0, 2, 0);
    do_start(16'd10);
    fork
      pulses(2, 3, 3, 0);
      watch(100, 4'd0, 16'd0, bn, lat, hb);
    join
    chk("post_rst_latency", lat, 11);
    repeat (3) @(negedge clk);

    chk("sb4_drained", q4.size(), 0);
    chk("sb16_drained", q16.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
